// File: rtl/dec_strobe_3x8_pkg.sv
// dec_pkg: shared types and constants for the 3-to-8 timed strobe driver.
//   state_t  : controller states (IDLE, DRIVE, GAP)
//   cnt_w()  : counter width for the pulse/gap down-counter
//   ONEHOT_W : strobe output width, CODE_W : select code width
package dec_pkg;

    localparam int unsigned ONEHOT_W = 8;
    localparam int unsigned CODE_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Wide enough to hold the larger of the two reload values, plus one bit of headroom.
    function automatic int unsigned cnt_w(input int unsigned pulse_len,
                                          input int unsigned gap_len);
        int unsigned m;
        m = (pulse_len > gap_len) ? pulse_len : gap_len;
        return 32'($clog2(m)) + 32'd1;
    endfunction

endpackage

// File: rtl/dec_strobe_3x8_if.sv
// dec_strobe_3x8_if: select-code handshake into the strobe driver.
//   in_valid / in_code / in_ready : valid/ready code transfer
//   in_par                        : even parity over in_code (DEC_PARITY_EN builds only)
//   master = upstream code source, slave = strobe driver
interface dec_strobe_3x8_if;
    import dec_pkg::*;

    logic              in_valid;
    logic [CODE_W-1:0] in_code;
    logic              in_ready;
`ifdef DEC_PARITY_EN
    logic              in_par;
`endif

    modport master (
        input  in_ready,
        output in_valid,
        output in_code
`ifdef DEC_PARITY_EN
        , output in_par
`endif
    );

    modport slave (
        output in_ready,
        input  in_valid,
        input  in_code
`ifdef DEC_PARITY_EN
        , input in_par
`endif
    );

endinterface

// File: rtl/dec_onehot_3x8.sv
// dec_onehot_3x8: combinational 3-bit code to 8-bit one-hot decoder, no enable.
//   code   : select code 0..7
//   onehot : 1 << code
module dec_onehot_3x8
    import dec_pkg::*;
(
    input  logic [CODE_W-1:0]   code,
    output logic [ONEHOT_W-1:0] onehot
);

    always_comb begin
        onehot = ONEHOT_W'(1) << code;
    end

endmodule

// File: rtl/dec_strobe_3x8.sv
// dec_strobe_3x8: accepts a select code and drives its one-hot strobe for PULSE_LEN
// cycles, then holds off new codes for GAP_LEN idle cycles.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   en       : block enable; low aborts a strobe and blocks accepts
//   bus      : slave side of the code handshake (in_valid, in_code, in_ready[, in_par])
//   Y        : registered one-hot strobe, zero when not driving
//   busy     : high in DRIVE or GAP
//   done     : high on the last cycle of a strobe
//   err      : one-cycle pulse after a parity-rejected code
// Build option: define DEC_PARITY_EN to add in_par checking and the err output.
module dec_strobe_3x8
    import dec_pkg::*;
#(
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP_LEN   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    dec_strobe_3x8_if.slave     bus,
    output logic [ONEHOT_W-1:0] Y,
    output logic                busy,
    output logic                done
`ifdef DEC_PARITY_EN
    , output logic              err
`endif
);

    localparam int unsigned   CW         = cnt_w(PULSE_LEN, GAP_LEN);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] GAP_LOAD   = (GAP_LEN != 0) ? CW'(GAP_LEN - 1) : {CW{1'b0}};

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ONEHOT_W-1:0] y_d;
    logic [ONEHOT_W-1:0] onehot;
    logic                code_ok;
`ifdef DEC_PARITY_EN
    logic                err_d;
`endif

    dec_onehot_3x8 u_onehot (
        .code   (bus.in_code),
        .onehot (onehot)
    );

    // Odd overall parity across code+par marks a corrupted code.
`ifdef DEC_PARITY_EN
    assign code_ok = ~(^bus.in_code ^ bus.in_par);
`else
    assign code_ok = 1'b1;
`endif

    // Ready is held low while reset is asserted so nothing is offered into a resetting block.
    assign bus.in_ready = (state_q == IDLE) && en && !rst;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DRIVE) && (cnt_q == '0) && en;

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            Y       <= '0;
`ifdef DEC_PARITY_EN
            err     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            Y       <= y_d;
`ifdef DEC_PARITY_EN
            err     <= err_d;
`endif
        end
    end

    // Next-state, counter and strobe value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = Y;
`ifdef DEC_PARITY_EN
        err_d   = 1'b0;
`endif
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            y_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (code_ok) begin
                            state_d = DRIVE;
                            cnt_d   = PULSE_LOAD;
                            y_d     = onehot;
                        end
`ifdef DEC_PARITY_EN
                        else begin
                            err_d = 1'b1;
                        end
`endif
                    end
                end
                DRIVE: begin
                    if (cnt_q == '0) begin
                        y_d = '0;
                        if (GAP_LEN != 0) begin
                            state_d = GAP;
                            cnt_d   = GAP_LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    y_d     = '0;
                end
            endcase
        end
    end

endmodule
